// File: rtl/db_gain_stage_pkg.sv
// Shared types and constants for the channel strip gain path.
// Gains are unsigned Q4.12; dB values are signed 8-bit with a reserved mute code.
package channel_strip_pkg;

    typedef logic [15:0] gain_t;

    localparam int               GAIN_FRAC  = 12;
    localparam gain_t            UNITY_GAIN = 16'd4096;
    localparam logic signed [7:0] MUTE_DB   = 8'h80;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        LOOKUP,
        COMMIT
    } gain_state_t;

    function automatic logic signed [15:0] sat16(input logic signed [32:0] value);
        if (value > 33'sd32767) begin
            return 16'sh7fff;
        end
        if (value < -33'sd32768) begin
            return 16'sh8000;
        end
        return $signed(value[15:0]);
    endfunction

endpackage

// File: rtl/db_gain_stage_if.sv
// Audio stream plus dB request/status signals of the gain stage.
// The master side supplies samples and requests; the slave side is the gain stage.
interface db_gain_stage_if;

    logic signed [15:0] inWave;
    logic               set_valid;
    logic               set_neg;
    logic [3:0]         set_num1;
    logic [3:0]         set_num0;
    logic               set_ready;
    logic               set_err;
    logic signed [7:0]  gain_db;
    logic               ramping;
    logic signed [15:0] outWave;

    modport master (
        output inWave, set_valid, set_neg, set_num1, set_num0,
        input  set_ready, set_err, gain_db, ramping, outWave
    );

    modport slave (
        input  inWave, set_valid, set_neg, set_num1, set_num0,
        output set_ready, set_err, gain_db, ramping, outWave
    );

endinterface

// File: rtl/db_gain_stage_rom.sv
// Synchronous dB -> linear Q4.12 lookup, address = dB - DB_MIN.
// Table contents are computed at elaboration from 10^(dB/20).
module db_to_lin_rom
    import channel_strip_pkg::*;
#(
    parameter int DB_MIN = -60,
    parameter int DB_MAX = 20
) (
    input  logic       clk_48,
    input  logic       reset_n,
    input  logic [6:0] addr,
    output gain_t      data
);

    localparam int DEPTH = DB_MAX - DB_MIN + 1;

    function automatic gain_t db_entry(input int db);
        real lin;
        lin = real'(UNITY_GAIN) * $pow(10.0, real'(db) / 20.0);
        return gain_t'($rtoi(lin + 0.5));
    endfunction

    gain_t table_q [128];

    // Unused addresses above the dB range read back as zero gain.
    for (genvar i = 0; i < 128; i++) begin : g_rom
        if (i < DEPTH) begin : g_entry
            localparam gain_t ENTRY = db_entry(i + DB_MIN);
            assign table_q[i] = ENTRY;
        end else begin : g_pad
            assign table_q[i] = '0;
        end
    end

    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            data <= '0;
        end else begin
            data <= table_q[addr];
        end
    end

endmodule

// File: rtl/db_gain_stage.sv
// dB-entered gain stage: BCD request decode, ROM lookup, ramped Q4.12 gain,
// and a two-stage multiply / round / saturate pipeline feeding the codec.
module db_gain_stage
    import channel_strip_pkg::*;
#(
    parameter int RAMP_STEP = 64,
    parameter int DB_MIN    = -60,
    parameter int DB_MAX    = 20
) (
    input  logic            clk_48,
    input  logic            reset_n,
    db_gain_stage_if.slave  bus
);

    localparam logic signed [16:0] STEP_S     = 17'(RAMP_STEP);
    localparam gain_t              STEP_G     = gain_t'(RAMP_STEP);
    localparam logic signed [32:0] ROUND_HALF = 33'sd1 <<< (GAIN_FRAC - 1);

    gain_state_t        state;
    gain_state_t        next_state;

    logic               set_ready;
    logic               set_err;
    logic               accept;
    logic               load_db;
    logic               commit;

    logic               req_neg;
    logic [3:0]         req_num1;
    logic [3:0]         req_num0;

    logic               digit_bad;
    logic               mute_req;
    logic signed [7:0]  db_next;
    int                 db_int;

    logic signed [7:0]  db_q;
    logic               mute_q;
    logic signed [7:0]  gain_db_q;

    logic [6:0]         rom_addr;
    gain_t              rom_data;

    gain_t              target_gain;
    gain_t              cur_gain;
    gain_t              cur_next;
    logic signed [16:0] gain_diff;

    logic signed [32:0] prod_q;
    logic signed [15:0] out_q;

    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.set_valid) next_state = DECODE;
            DECODE:  next_state = digit_bad ? IDLE : LOOKUP;
            LOOKUP:  next_state = COMMIT;
            COMMIT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        set_ready = (state == IDLE);
        set_err   = (state == DECODE) && digit_bad;
        accept    = (state == IDLE) && bus.set_valid;
        load_db   = (state == DECODE) && !digit_bad;
        commit    = (state == COMMIT);
    end

    // Digit decode works on the captured request, so the live inputs are free to change.
    always_comb begin
        digit_bad = (req_num1 > 4'd9) || (req_num0 > 4'd9);
        db_int    = int'(req_num1) * 10 + int'(req_num0);
        if (req_neg) begin
            db_int = -db_int;
        end
        mute_req = (db_int < DB_MIN);
        if (db_int > DB_MAX) begin
            db_int = DB_MAX;
        end
        db_next = 8'(db_int);
    end

    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            req_neg     <= 1'b0;
            req_num1    <= '0;
            req_num0    <= '0;
            db_q        <= '0;
            mute_q      <= 1'b0;
            gain_db_q   <= '0;
            target_gain <= UNITY_GAIN;
        end else begin
            if (accept) begin
                req_neg  <= bus.set_neg;
                req_num1 <= bus.set_num1;
                req_num0 <= bus.set_num0;
            end
            if (load_db) begin
                db_q   <= mute_req ? 8'(DB_MIN) : db_next;
                mute_q <= mute_req;
            end
            if (commit) begin
                target_gain <= mute_q ? gain_t'(0) : rom_data;
                gain_db_q   <= mute_q ? MUTE_DB : db_q;
            end
        end
    end

    assign rom_addr = 7'(int'(db_q) - DB_MIN);

    db_to_lin_rom #(
        .DB_MIN (DB_MIN),
        .DB_MAX (DB_MAX)
    ) u_rom (
        .clk_48  (clk_48),
        .reset_n (reset_n),
        .addr    (rom_addr),
        .data    (rom_data)
    );

    // Ramp always starts from the present cur_gain, so a retarget never jumps.
    always_comb begin
        gain_diff = $signed({1'b0, target_gain}) - $signed({1'b0, cur_gain});
        if (gain_diff > STEP_S) begin
            cur_next = cur_gain + STEP_G;
        end else if (gain_diff < -STEP_S) begin
            cur_next = cur_gain - STEP_G;
        end else begin
            cur_next = target_gain;
        end
    end

    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            cur_gain <= UNITY_GAIN;
        end else begin
            cur_gain <= cur_next;
        end
    end

    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            prod_q <= '0;
            out_q  <= '0;
        end else begin
            prod_q <= $signed(bus.inWave) * $signed({1'b0, cur_gain});
            out_q  <= sat16((prod_q + ROUND_HALF) >>> GAIN_FRAC);
        end
    end

    assign bus.set_ready = set_ready;
    assign bus.set_err   = set_err;
    assign bus.gain_db   = gain_db_q;
    assign bus.ramping   = (cur_gain != target_gain);
    assign bus.outWave   = out_q;

endmodule

// File: tb/tb_db_gain_stage.sv
// Directed bench for db_gain_stage: unity path, dB requests, clamp, mute,
// digit errors, ignored requests while busy, and asynchronous reset mid-ramp.
module tb_db_gain_stage;

    logic clk_48;
    logic reset_n;
    int   checks;
    int   errors;
    int   ramp_cycles;

    db_gain_stage_if bus();

    db_gain_stage dut (
        .clk_48  (clk_48),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk_48 = 1'b0;
    always #5 clk_48 = ~clk_48;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] simulation timed out");
    end

    task automatic tick();
        @(posedge clk_48);
        #1;
    endtask

    task automatic check_output(input string tag, input logic signed [31:0] observed,
                                input logic signed [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic send_request(input logic neg, input logic [3:0] num1, input logic [3:0] num0);
        bus.set_valid = 1'b1;
        bus.set_neg   = neg;
        bus.set_num1  = num1;
        bus.set_num0  = num0;
        tick();
        bus.set_valid = 1'b0;
    endtask

    task automatic wait_ramp(input int budget, output int cycles);
        cycles = 0;
        while (bus.ramping === 1'b1 && cycles < budget) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset_n       = 1'b0;
        bus.inWave    = '0;
        bus.set_valid = 1'b0;
        bus.set_neg   = 1'b0;
        bus.set_num1  = '0;
        bus.set_num0  = '0;

        #12;
        check_output("rst_outWave",    32'($signed(bus.outWave)), 0);
        check_output("rst_set_ready",  32'(bus.set_ready), 1);
        check_output("rst_set_err",    32'(bus.set_err), 0);
        check_output("rst_gain_db",    32'($signed(bus.gain_db)), 0);
        check_output("rst_ramping",    32'(bus.ramping), 0);

        tick();
        reset_n    = 1'b1;
        bus.inWave = 16'sd1000;
        tick();
        check_output("unity_lat1", 32'($signed(bus.outWave)), 0);
        tick();
        check_output("unity_out",  32'($signed(bus.outWave)), 1000);
        check_output("unity_ramping", 32'(bus.ramping), 0);
        check_output("unity_gain_db", 32'($signed(bus.gain_db)), 0);

        send_request(1'b1, 4'd0, 4'd6);
        check_output("m6_busy", 32'(bus.set_ready), 0);
        tick();
        tick();
        check_output("m6_not_yet", 32'($signed(bus.gain_db)), 0);
        tick();
        check_output("m6_gain_db", 32'($signed(bus.gain_db)), -6);
        check_output("m6_ramping", 32'(bus.ramping), 1);
        check_output("m6_ready_back", 32'(bus.set_ready), 1);
        wait_ramp(100, ramp_cycles);
        check_output("m6_ramp_cycles", ramp_cycles, 32);
        tick();
        tick();
        check_output("m6_out", 32'($signed(bus.outWave)), 501);

        send_request(1'b0, 4'd2, 4'd5);
        tick();
        tick();
        tick();
        check_output("p25_gain_db", 32'($signed(bus.gain_db)), 20);
        wait_ramp(1000, ramp_cycles);
        check_output("p25_ramp_cycles", ramp_cycles, 608);
        bus.inWave = 16'sd16000;
        tick();
        tick();
        check_output("p25_sat_pos", 32'($signed(bus.outWave)), 32767);
        bus.inWave = -16'sd32768;
        tick();
        tick();
        check_output("p25_sat_neg", 32'($signed(bus.outWave)), -32768);

        send_request(1'b1, 4'd6, 4'd1);
        tick();
        tick();
        tick();
        check_output("mute_gain_db", 32'($signed(bus.gain_db)), -128);
        wait_ramp(1000, ramp_cycles);
        check_output("mute_ramp_cycles", ramp_cycles, 640);
        bus.inWave = 16'sd12345;
        tick();
        tick();
        check_output("mute_out_pos", 32'($signed(bus.outWave)), 0);
        bus.inWave = -16'sd32768;
        tick();
        tick();
        check_output("mute_out_neg", 32'($signed(bus.outWave)), 0);

        bus.set_valid = 1'b1;
        bus.set_neg   = 1'b0;
        bus.set_num1  = 4'd1;
        bus.set_num0  = 4'hC;
        tick();
        check_output("err_pulse", 32'(bus.set_err), 1);
        bus.set_num0 = 4'd5;
        tick();
        bus.set_valid = 1'b0;
        check_output("err_pulse_end", 32'(bus.set_err), 0);
        check_output("err_ready", 32'(bus.set_ready), 1);
        for (int i = 0; i < 6; i++) begin
            tick();
        end
        check_output("err_gain_db_kept", 32'($signed(bus.gain_db)), -128);
        check_output("err_no_ramp", 32'(bus.ramping), 0);

        send_request(1'b1, 4'd0, 4'd0);
        tick();
        tick();
        tick();
        check_output("neg0_gain_db", 32'($signed(bus.gain_db)), 0);
        check_output("neg0_ramping", 32'(bus.ramping), 1);
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        check_output("neg0_mid_ramp", 32'(bus.ramping), 1);
        bus.inWave = 16'sd1000;
        reset_n    = 1'b0;
        #1;
        check_output("arst_outWave", 32'($signed(bus.outWave)), 0);
        check_output("arst_ramping", 32'(bus.ramping), 0);
        check_output("arst_gain_db", 32'($signed(bus.gain_db)), 0);
        check_output("arst_ready",   32'(bus.set_ready), 1);
        tick();
        reset_n = 1'b1;
        tick();
        check_output("post_rst_lat1", 32'($signed(bus.outWave)), 0);
        tick();
        check_output("post_rst_out", 32'($signed(bus.outWave)), 1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
